// File: rtl/serial_sub.sv
// Multi-cycle unsigned subtractor: computes input1 - input2 K bits per clock,
// LSB chunk first, with the borrow carried between cycles; result is {borrow, diff}.
module serial_sub #(
    parameter int N = 50,
    parameter int K = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] input1,
    input  logic [N-1:0] input2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   result
);

    localparam int NC = N / K;
    localparam int CW = (NC > 1) ? $clog2(NC) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_reg;
    state_t         state_next;
    logic [N-1:0]   a_reg;
    logic [N-1:0]   b_reg;
    logic [CW-1:0]  cnt_reg;
    logic           borrow_reg;
    logic [N-1:0]   diff_reg;
    logic           bout_reg;

    logic [K-1:0]   a_chunk_arr [NC];
    logic [K-1:0]   b_chunk_arr [NC];
    logic [K-1:0]   a_chunk;
    logic [K-1:0]   b_chunk;
    logic [K:0]     sub_full;
    logic           last_chunk;
    logic           accept;

    // Slice the latched operands into per-chunk views so the active chunk is a plain mux.
    generate
        for (genvar gi = 0; gi < NC; gi++) begin : g_chunk
            assign a_chunk_arr[gi] = a_reg[gi*K +: K];
            assign b_chunk_arr[gi] = b_reg[gi*K +: K];
        end
    endgenerate

    assign a_chunk    = a_chunk_arr[cnt_reg];
    assign b_chunk    = b_chunk_arr[cnt_reg];
    // The extra MSB of the K+1-bit difference is the borrow out of this chunk.
    assign sub_full   = {1'b0, a_chunk} - {1'b0, b_chunk} - {{K{1'b0}}, borrow_reg};
    assign last_chunk = (cnt_reg == CW'(NC - 1));
    assign accept     = in_valid && (state_reg == IDLE);

    assign in_ready   = (state_reg == IDLE);
    assign out_valid  = (state_reg == DONE);
    assign result     = {bout_reg, diff_reg};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)   state_next = RUN;
            RUN:     if (last_chunk) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            cnt_reg    <= '0;
            borrow_reg <= 1'b0;
            diff_reg   <= '0;
            bout_reg   <= 1'b0;
        end else if (accept) begin
            a_reg      <= input1;
            b_reg      <= input2;
            cnt_reg    <= '0;
            borrow_reg <= 1'b0;
        end else if (state_reg == RUN) begin
            borrow_reg <= sub_full[K];
            cnt_reg    <= last_chunk ? '0 : cnt_reg + CW'(1);
            for (int i = 0; i < NC; i++) begin
                if (cnt_reg == CW'(i)) begin
                    diff_reg[i*K +: K] <= sub_full[K-1:0];
                end
            end
            if (last_chunk) begin
                bout_reg <= sub_full[K];
            end
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Randomised and directed bench for serial_sub, checked against an arithmetic
// reference ((a - b) mod 2^(N+1)) plus handshake timing expectations.
module tb_serial_sub;

    localparam int N  = 50;
    localparam int K  = 10;
    localparam int NC = N / K;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] input1 = '0;
    logic [N-1:0] input2 = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N:0]   result;

    int vectors = 0;
    int miscompares = 0;

    serial_sub #(.N(N), .K(K)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .input1    (input1),
        .input2    (input2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
        return {1'b0, a} - {1'b0, b};
    endfunction

    function automatic logic [N-1:0] rand_op();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[N-1:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One operation: present operands, wait for the result, then hand it off after
    // 'hold' stalled cycles (or immediately when out_ready is already high).
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input int hold, input bit pre_ready, input bit pulse);
        logic [N:0] exp;
        int lat;
        exp = model(a, b);
        @(negedge clk);
        input1 = a; input2 = b; in_valid = 1'b1; out_ready = pre_ready;
        check("in_ready_idle", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0; input1 = rand_op(); input2 = rand_op();
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'(NC));
        check("result", 64'(result), 64'(exp));
        $display("op a=%h b=%h result=%h expected=%h hold=%0d pre_ready=%0d",
                 a, b, result, exp, hold, pre_ready);
        if (pre_ready) begin
            @(negedge clk);
            check("single_cycle_valid", 64'({out_valid, in_ready}), 64'b01);
        end else begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                in_valid = pulse && (i == 1);
                input1 = rand_op(); input2 = rand_op();
                check("stall_valid", 64'({out_valid, in_ready}), 64'b10);
                check("stall_result", 64'(result), 64'(exp));
            end
            @(negedge clk);
            in_valid = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            check("handoff", 64'({out_valid, in_ready}), 64'b01);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        logic [N-1:0] a2, b2;
        int gap;
        int seen;

        #12;
        check("reset_state", 64'({out_valid, in_ready, result}), 64'({1'b0, 1'b1, {(N+1){1'b0}}}));
        @(negedge clk);
        reset_n = 1'b1;

        // Directed corners, including borrow ripple across every chunk boundary.
        run_op(50'd5, 50'd5, 0, 1'b0, 1'b0);
        run_op(50'd3, 50'd5, 1, 1'b0, 1'b0);
        check("const_3_minus_5", 64'(result), 64'h7FFFFFFFFFFFE);
        run_op(50'h100_0000_0000, 50'd1, 0, 1'b1, 1'b0);
        run_op(50'd0, {N{1'b1}}, 0, 1'b0, 1'b0);
        check("const_0_minus_max", 64'(result), 64'h4000000000001);
        run_op({N{1'b1}}, 50'd0, 0, 1'b0, 1'b0);
        run_op(rand_op(), rand_op(), 3, 1'b0, 1'b1);

        // Reset two cycles into RUN discards the operation.
        @(negedge clk);
        input1 = 50'd123; input2 = 50'd45; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check("reset_mid_run", 64'({out_valid, in_ready, result}), 64'({1'b0, 1'b1, {(N+1){1'b0}}}));
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no_valid_after_abort", 64'(seen), 64'd0);
        run_op(50'd7, 50'd2, 0, 1'b0, 1'b0);
        check("seven_minus_two", 64'(result), 64'd5);

        // in_valid held high with out_ready high: one op per NC+2 cycles, no double capture.
        a2 = rand_op(); b2 = rand_op();
        @(negedge clk);
        input1 = 50'd1000; input2 = 50'd1; in_valid = 1'b1; out_ready = 1'b1;
        gap = 0;
        while (!out_valid && gap < 20) begin
            @(negedge clk);
            gap++;
        end
        check("b2b_first", 64'(result), 64'(model(50'd1000, 50'd1)));
        input1 = a2; input2 = b2;
        gap = 0;
        @(negedge clk);
        while (!out_valid && gap < 20) begin
            @(negedge clk);
            gap++;
        end
        check("b2b_gap", 64'(gap + 1), 64'(NC + 2));
        check("b2b_second", 64'(result), 64'(model(a2, b2)));
        $display("b2b second a=%h b=%h result=%h gap=%0d", a2, b2, result, gap + 1);
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);

        // Randomised operations with random backpressure.
        for (int t = 0; t < 24; t++) begin
            logic [N-1:0] ra, rb;
            ra = rand_op();
            rb = (t % 3 == 0) ? ra + 50'($urandom_range(0, 3)) : rand_op();
            run_op(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
